// File: rtl/result_pack_buffer.sv
// Packs pairs of DATA_W adder results into MEM_WORD_SIZE words and queues them for the controller.
// Optional partial-word flush port is enabled by defining RESULT_PACK_BUFFER_FLUSH_EN.
module result_pack_buffer #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int OUT_DEPTH     = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             buffer_control_i,
  input  logic                             res_valid_i,
  input  logic [DATA_W-1:0]                res_data_i,
  output logic                             res_ready_o,
  output logic                             word_valid_o,
  input  logic                             word_ready_i,
  output logic [MEM_WORD_SIZE-1:0]         buff_result_o,
`ifdef RESULT_PACK_BUFFER_FLUSH_EN
  input  logic                             flush_i,
`endif
  output logic [$clog2(OUT_DEPTH+1)-1:0]   count_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on the same-cycle pop, only on registered occupancy.
  localparam int CW = $clog2(OUT_DEPTH+1);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

  typedef enum logic [1:0] {S_EMPTY, S_HALF, S_FULL} state_e;

  state_e              state_q, state_d;
  logic                lo_v_q, lo_v_d, hi_v_q, hi_v_d;
  logic [DATA_W-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic [MEM_WORD_SIZE-1:0] mem_q [OUT_DEPTH];
  logic [PW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       count_q;
  logic                room, commit, flush_push, push, pop, accept, sel_v;
  logic [MEM_WORD_SIZE-1:0] push_word;

  assign room   = (count_q < DEPTH_C);
  assign commit = (state_q == S_FULL) && room && !clear_i;
`ifdef RESULT_PACK_BUFFER_FLUSH_EN
  assign flush_push = flush_i && (state_q == S_HALF) && room && !clear_i;
`else
  assign flush_push = 1'b0;
`endif
  assign push   = commit || flush_push;
  assign sel_v  = buffer_control_i ? hi_v_q : lo_v_q;
  assign res_ready_o = rst_ni && !clear_i && (!sel_v || commit);
  assign accept = res_valid_i && res_ready_o;
  assign pop    = word_valid_o && word_ready_i && !clear_i;

  // Invalid halves are zero-filled, which only matters for a flushed partial word.
  assign push_word = {(hi_v_q ? hi_q : {DATA_W{1'b0}}), (lo_v_q ? lo_q : {DATA_W{1'b0}})};

  always_comb begin
    lo_v_d = lo_v_q;
    hi_v_d = hi_v_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    if (clear_i) begin
      lo_v_d = 1'b0;
      hi_v_d = 1'b0;
    end else begin
      if (push) begin
        lo_v_d = 1'b0;
        hi_v_d = 1'b0;
      end
      if (accept) begin
        if (buffer_control_i) begin
          hi_d   = res_data_i;
          hi_v_d = 1'b1;
        end else begin
          lo_d   = res_data_i;
          lo_v_d = 1'b1;
        end
      end
    end
    if (lo_v_d && hi_v_d)      state_d = S_FULL;
    else if (lo_v_d || hi_v_d) state_d = S_HALF;
    else                       state_d = S_EMPTY;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      lo_v_q  <= 1'b0;
      hi_v_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      lo_v_q  <= lo_v_d;
      hi_v_q  <= hi_v_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= push_word;
  end

  assign word_valid_o  = (count_q != '0);
  assign buff_result_o = word_valid_o ? mem_q[rd_q] : '0;
  assign count_o       = count_q;

endmodule
